// File: rtl/lv_pkg.sv
// Shared definitions for the LV-die one-wire transmit path.
// Contents:
//   owt_tx_st_e        serializer states (IDLE, SYNC, BITS, GAP)
//   LV_OWT_SYNC_HI_HB  half-bits driven high at frame start
//   LV_OWT_SYNC_LO_HB  half-bits driven low after the high run of the sync
//   owt_even_par       even parity over a zero-extended word
package lv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        BITS = 2'd2,
        GAP  = 2'd3
    } owt_tx_st_e;

    // Three high half-bits in a row never occur in valid Manchester data,
    // so this run marks the start of a frame unambiguously.
    localparam int LV_OWT_SYNC_HI_HB = 3;
    localparam int LV_OWT_SYNC_LO_HB = 1;

    // Even parity: the XOR of all bits. Callers zero-extend narrower words.
    function automatic logic owt_even_par(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lv_owt_rr_arb.sv
// Channel arbiter for the one-wire transmitter.
// Round-robin (mode_i=0) searches from ptr_i upward with wrap-around and
// proposes the granted index plus one as the next pointer. Fixed priority
// (mode_i=1) grants the lowest requesting index and keeps the pointer.
// Ports:
//   req_i      per-channel request (buffer full)
//   ptr_i      current round-robin start pointer
//   mode_i     0: round-robin, 1: fixed priority
//   en_i       arbitration allowed this cycle
//   gnt_o      one-hot grant (all zero when nothing is granted)
//   idx_o      encoded index of the grant
//   ptr_nxt_o  pointer value to store when the grant is taken
module lv_owt_rr_arb
    import lv_pkg::*;
#(
    parameter  int CH_NUM = 4,
    localparam int CID_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic [CH_NUM-1:0] req_i,
    input  logic [CID_W-1:0]  ptr_i,
    input  logic              mode_i,
    input  logic              en_i,
    output logic [CH_NUM-1:0] gnt_o,
    output logic [CID_W-1:0]  idx_o,
    output logic [CID_W-1:0]  ptr_nxt_o
);

    logic             found_s;
    logic [CID_W-1:0] cand_s;

    // Priority search: first requesting candidate in search order wins.
    always_comb begin
        gnt_o     = '0;
        idx_o     = '0;
        ptr_nxt_o = ptr_i;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (mode_i) begin
                cand_s = CID_W'(i);
            end else begin
                cand_s = CID_W'((int'(ptr_i) + i) % CH_NUM);
            end
            if (en_i && !found_s && req_i[cand_s]) begin
                found_s       = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
                if (mode_i) begin
                    ptr_nxt_o = ptr_i;
                end else begin
                    ptr_nxt_o = CID_W'((int'(cand_s) + 1) % CH_NUM);
                end
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/lv_owt_tx_mch.sv
// Multi-channel Manchester one-wire transmitter (LV to HV isolation link).
// Each channel has a single-entry buffer; an arbiter picks a full buffer
// while idle and the serializer sends SYNC, {id, data, parity} MSB first
// as Manchester bits, then a forced-low GAP.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_tx_en          allows new frames to start (a running frame always completes)
//   i_prio_mode      0: round-robin, 1: fixed priority (channel 0 highest)
//   i_tx_vld         per-channel data valid
//   i_tx_data        per-channel data, channel c at [c*DATA_W +: DATA_W]
//   o_tx_rdy         per-channel buffer empty
//   o_lv_hv_owt_tx   serial line, straight from a flop
//   o_busy           high from SYNC entry to the end of GAP
//   o_cur_ch         channel of the frame in flight
//   o_frm_done       one-cycle pulse in the last GAP cycle
module lv_owt_tx_mch
    import lv_pkg::*;
#(
    parameter  int CH_NUM = 4,
    parameter  int DATA_W = 8,
    parameter  int HB_CYC = 4,
    parameter  int GAP_HB = 2,
    localparam int CID_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_tx_en,
    input  logic                     i_prio_mode,
    input  logic [CH_NUM-1:0]        i_tx_vld,
    input  logic [CH_NUM*DATA_W-1:0] i_tx_data,
    output logic [CH_NUM-1:0]        o_tx_rdy,
    output logic                     o_lv_hv_owt_tx,
    output logic                     o_busy,
    output logic [CID_W-1:0]         o_cur_ch,
    output logic                     o_frm_done
);

    localparam int FRM_W   = CID_W + DATA_W + 1;
    localparam int BITS_HB = 2 * FRM_W;
    localparam int SYNC_HB = LV_OWT_SYNC_HI_HB + LV_OWT_SYNC_LO_HB;
    localparam int IDX_N   = (BITS_HB > GAP_HB) ? BITS_HB : GAP_HB;
    localparam int IDX_W   = $clog2(IDX_N);
    localparam int CNT_W   = $clog2(HB_CYC);

    owt_tx_st_e        st_q, st_d, st_nxt_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_last_s;
    logic [FRM_W-1:0]  shift_q, shift_d, bit_sel_s;
    logic [CID_W-1:0]  cur_q, cur_d, ptr_q, ptr_d;
    logic [CH_NUM-1:0] rdy_q, rdy_d;
    logic              line_q, line_d, busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] buf_q [CH_NUM];

    logic [CH_NUM-1:0] gnt_s;
    logic [CID_W-1:0]  gnt_idx_s, ptr_nxt_s;
    logic [DATA_W-1:0] gnt_data_s;
    logic [FRM_W-1:0]  gnt_word_s;
    logic              hb_last_s;

    lv_owt_rr_arb #(.CH_NUM(CH_NUM)) u_arb (
        .req_i     (~rdy_q),
        .ptr_i     (ptr_q),
        .mode_i    (i_prio_mode),
        .en_i      ((st_q == IDLE) && i_tx_en),
        .gnt_o     (gnt_s),
        .idx_o     (gnt_idx_s),
        .ptr_nxt_o (ptr_nxt_s)
    );

    assign gnt_data_s = buf_q[gnt_idx_s];
    assign gnt_word_s = {gnt_idx_s, gnt_data_s, owt_even_par(32'({gnt_idx_s, gnt_data_s}))};
    assign hb_last_s  = (cnt_q == CNT_W'(HB_CYC - 1));

    // Length (in half-bits) of the current state and the state that follows it.
    always_comb begin
        case (st_q)
            SYNC: begin
                idx_last_s = IDX_W'(SYNC_HB - 1);
                st_nxt_s   = BITS;
            end
            BITS: begin
                idx_last_s = IDX_W'(BITS_HB - 1);
                st_nxt_s   = GAP;
            end
            GAP: begin
                idx_last_s = IDX_W'(GAP_HB - 1);
                st_nxt_s   = IDLE;
            end
            default: begin
                idx_last_s = '0;
                st_nxt_s   = IDLE;
            end
        endcase
    end

    // Next state, half-bit counters, buffer flags and arbitration pointer.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        rdy_d   = rdy_q & ~i_tx_vld;
        case (st_q)
            IDLE: begin
                if (|gnt_s) begin
                    st_d    = SYNC;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = gnt_word_s;
                    cur_d   = gnt_idx_s;
                    ptr_d   = ptr_nxt_s;
                    // Buffer frees on grant so the producer may reload at once.
                    rdy_d   = rdy_d | gnt_s;
                end else begin
                    st_d = IDLE;
                end
            end
            default: begin
                if (hb_last_s) begin
                    cnt_d = '0;
                    if (idx_q == idx_last_s) begin
                        st_d  = st_nxt_s;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // registered line lines up exactly with the state it belongs to.
    always_comb begin
        bit_sel_s = shift_d >> (FRM_W - 1 - int'(idx_d >> 1));
        case (st_d)
            IDLE:    line_d = 1'b0;
            SYNC:    line_d = (idx_d < IDX_W'(LV_OWT_SYNC_HI_HB));
            // Bit 1 is high then low: the first half carries the bit value.
            BITS:    line_d = bit_sel_s[0] ^ idx_d[0];
            GAP:     line_d = 1'b0;
            default: line_d = 1'b0;
        endcase
        busy_d = (st_d != IDLE);
        done_d = (st_d == GAP) && (cnt_d == CNT_W'(HB_CYC - 1)) && (idx_d == IDX_W'(GAP_HB - 1));
    end

    // Serializer state and registered outputs; reset aborts any frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q    <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            cur_q   <= '0;
            ptr_q   <= '0;
            rdy_q   <= '1;
            line_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            rdy_q   <= rdy_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Per-channel single-entry data buffers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                buf_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (i_tx_vld[c] && rdy_q[c]) begin
                    buf_q[c] <= i_tx_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign o_tx_rdy       = rdy_q;
    assign o_lv_hv_owt_tx = line_q;
    assign o_busy         = busy_q;
    assign o_cur_ch       = cur_q;
    assign o_frm_done     = done_q;

endmodule

// File: tb/tb_lv_owt_tx_mch.sv
// Scoreboard bench for lv_owt_tx_mch: stimulus pushes the expected frames
// in the order they must appear; monitors capture the serial line while
// o_busy is high and, on o_frm_done, decode and compare against the queue.
module tb_lv_owt_tx_mch;

    typedef struct {
        int          ch;
        logic [10:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, prio;
    logic [3:0]  vld, rdy;
    logic [31:0] data;
    logic        line, busy, done;
    logic [1:0]  cur;
    logic [1:0]  b_vld, b_rdy;
    logic [23:0] b_data;
    logic        b_line, b_busy, b_done;
    logic [0:0]  b_cur;

    int   errors = 0;
    int   checks = 0;
    int   a_frames = 0;
    int   b_frames = 0;
    exp_t exp_q[$];
    logic a_samp[$];
    logic b_samp[$];
    logic [31:0] a_w, b_w;
    bit   a_ok, b_ok;
    exp_t a_e;

    always #5 clk = ~clk;

    lv_owt_tx_mch u_dut (
        .i_clk(clk), .i_rst(rst), .i_tx_en(en), .i_prio_mode(prio),
        .i_tx_vld(vld), .i_tx_data(data), .o_tx_rdy(rdy),
        .o_lv_hv_owt_tx(line), .o_busy(busy), .o_cur_ch(cur), .o_frm_done(done)
    );

    lv_owt_tx_mch #(.CH_NUM(2), .DATA_W(12), .HB_CYC(2), .GAP_HB(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_tx_en(en), .i_prio_mode(prio),
        .i_tx_vld(b_vld), .i_tx_data(b_data), .o_tx_rdy(b_rdy),
        .o_lv_hv_owt_tx(b_line), .o_busy(b_busy), .o_cur_ch(b_cur), .o_frm_done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] model_word(input logic [1:0] ch, input logic [7:0] d);
        return {ch, d, ^{ch, d}};
    endfunction

    // Decode a captured frame: sync 1,1,1,0; nb Manchester bits; gap low.
    function automatic void decode(input logic s[$], input int hb, input int nb, input int gap,
                                   output logic [31:0] word, output bit ok);
        int nh;
        logic a, c;
        nh   = 4 + 2 * nb + gap;
        word = 32'd0;
        ok   = (s.size() == nh * hb);
        if (ok) begin
            for (int k = 0; k < nh; k++)
                for (int j = 1; j < hb; j++)
                    if (s[k*hb+j] !== s[k*hb]) ok = 1'b0;
            if (s[0] !== 1'b1 || s[hb] !== 1'b1 || s[2*hb] !== 1'b1 || s[3*hb] !== 1'b0) ok = 1'b0;
            for (int b = 0; b < nb; b++) begin
                a = s[(4 + 2*b) * hb];
                c = s[(5 + 2*b) * hb];
                if (a === c) ok = 1'b0;
                word = {word[30:0], a};
            end
            for (int g = 0; g < gap; g++)
                if (s[(4 + 2*nb + g) * hb] !== 1'b0) ok = 1'b0;
        end
    endfunction

    // Monitor for the default-parameter instance.
    always @(negedge clk) begin
        if (rst) begin
            a_samp.delete();
        end else begin
            if (busy) a_samp.push_back(line);
            if (done) begin
                a_frames++;
                chk("a_frame_len", a_samp.size(), 32'd112);
                decode(a_samp, 4, 11, 2, a_w, a_ok);
                chk("a_manchester", {31'd0, a_ok}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("a_unexpected_frame", a_w, 32'hFFFF_FFFF);
                end else begin
                    a_e = exp_q.pop_front();
                    chk("a_word", a_w, {21'd0, a_e.word});
                    chk("a_cur_ch", {30'd0, cur}, a_e.ch);
                end
                a_samp.delete();
            end
        end
    end

    // Monitor for the small instance (CH_NUM=2, DATA_W=12, HB_CYC=2, GAP_HB=1).
    always @(negedge clk) begin
        if (rst) begin
            b_samp.delete();
        end else begin
            if (b_busy) b_samp.push_back(b_line);
            if (b_done) begin
                b_frames++;
                chk("b_frame_len", b_samp.size(), 32'd66);
                decode(b_samp, 2, 14, 1, b_w, b_ok);
                chk("b_manchester", {31'd0, b_ok}, 32'd1);
                chk("b_word", b_w, 32'h0000_3FFF);
                chk("b_cur_ch", {31'd0, b_cur}, 32'd1);
                b_samp.delete();
            end
        end
    end

    task automatic push(input int ch, input logic [7:0] d);
        exp_t e;
        e.ch   = ch;
        e.word = model_word(ch[1:0], d);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_vld(input logic [3:0] m);
        vld = m;
        @(negedge clk);
        vld = 4'd0;
    endtask

    task automatic wait_cur(input int ch);
        int n;
        n = 0;
        while (!(busy && cur == ch[1:0]) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cur_ch", {31'd0, busy && cur == ch[1:0]}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; prio = 1'b0; vld = 4'd0; data = 32'd0;
        b_vld = 2'd0; b_data = 24'd0;
        repeat (2) @(negedge clk);
        chk("rst_line", {31'd0, line}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cur", {30'd0, cur}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdy", {28'd0, rdy}, 32'hF);
        chk("rst_rdy_b", {30'd0, b_rdy}, 32'h3);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single frame: ch2 0xA5 -> 10 10100101 1
        data[23:16] = 8'hA5;
        begin
            exp_t e;
            e.ch = 2; e.word = 11'b10_10100101_1;
            exp_q.push_back(e);
        end
        pulse_vld(4'b0100);                       // now in cycle t+1
        chk("t1_rdy2_low", {31'd0, rdy[2]}, 32'd0);
        chk("t1_line_t1", {31'd0, line}, 32'd0);
        @(negedge clk);                           // t+2
        chk("t1_rdy2_back", {31'd0, rdy[2]}, 32'd1);
        chk("t1_line_t2", {31'd0, line}, 32'd1);
        chk("t1_busy_t2", {31'd0, busy}, 32'd1);
        chk("t1_cur_t2", {30'd0, cur}, 32'd2);
        repeat (11) @(negedge clk);               // t+13
        chk("t1_line_t13", {31'd0, line}, 32'd1);
        @(negedge clk);                           // t+14
        chk("t1_line_t14", {31'd0, line}, 32'd0);
        repeat (98) @(negedge clk);               // t+112
        chk("t1_done_t112", {31'd0, done}, 32'd0);
        @(negedge clk);                           // t+113
        chk("t1_done_t113", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // Round-robin: all four at once, ch0 reloaded during ch1's frame.
        do_reset();
        prio = 1'b0;
        data = 32'h4433_2211;
        push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h55);
        pulse_vld(4'b1111);
        wait_cur(1);
        data[7:0] = 8'h55;
        pulse_vld(4'b0001);
        wait_drain(1000);

        // Fixed priority with pointer parked at 2 by a prior RR grant of ch1.
        do_reset();
        data[15:8] = 8'h5C;
        push(1, 8'h5C); push(1, 8'h1E); push(3, 8'h3C);
        push(0, 8'h0F); push(1, 8'h81); push(3, 8'h7E);
        pulse_vld(4'b0010);
        wait_cur(1);
        prio = 1'b1;
        data[15:8] = 8'h1E; data[31:24] = 8'h3C;
        pulse_vld(4'b1010);
        wait_cur(3);
        data[7:0] = 8'h0F; data[15:8] = 8'h81; data[31:24] = 8'h7E;
        pulse_vld(4'b1011);
        wait_drain(1000);
        // Back to RR: pointer still 2 -> ch2 before ch1.
        prio = 1'b0;
        data[15:8] = 8'hA1; data[23:16] = 8'hB2;
        push(2, 8'hB2); push(1, 8'hA1);
        pulse_vld(4'b0110);
        wait_drain(600);

        // Transmit enable: held off, then dropped mid-frame.
        do_reset();
        en = 1'b0;
        data[7:0] = 8'h5A;
        pulse_vld(4'b0001);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("en0_line", {31'd0, line}, 32'd0);
        end
        chk("en0_rdy0", {31'd0, rdy[0]}, 32'd0);
        chk("en0_busy", {31'd0, busy}, 32'd0);
        push(0, 8'h5A); push(1, 8'hC3);
        en = 1'b1;
        wait_cur(0);
        data[15:8] = 8'hC3;
        pulse_vld(4'b0010);
        repeat (30) @(negedge clk);
        en = 1'b0;
        begin
            int n;
            n = 0;
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("en_drop_frame_done", {31'd0, done}, 32'd1);
        end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            chk("en_drop_idle_busy", {31'd0, busy}, 32'd0);
        end
        chk("en_drop_rdy1_held", {31'd0, rdy[1]}, 32'd0);
        chk("en_drop_pending", exp_q.size(), 32'd1);
        en = 1'b1;
        wait_drain(400);

        // Reset during BITS, then a clean frame.
        do_reset();
        data[23:16] = 8'h99;
        pulse_vld(4'b0100);
        wait_cur(2);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_line", {31'd0, line}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_rdy", {28'd0, rdy}, 32'hF);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        data[15:8] = 8'h3D;
        push(1, 8'h3D);
        pulse_vld(4'b0010);
        wait_drain(400);

        // Alternate parameter set: ch1 0xFFF.
        b_data[23:12] = 12'hFFF;
        b_vld = 2'b10;
        @(negedge clk);
        b_vld = 2'b00;
        begin
            int n;
            n = 0;
            while (b_frames == 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("b_frame_count", b_frames, 32'd1);
        chk("a_frame_count", a_frames, 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
